// File: rtl/zigzag_rle_pkg.sv
// Shared types and constants for the zigzag run-length stage.
package zigzag_rle_pkg;

  localparam int unsigned NUM_COEFFS      = 64;
  localparam int unsigned RUN_MAX         = 15;
  localparam int unsigned ZRL_MAX         = 3;
  // Width of the level field carried in the symbol register; matches the default LEVEL_WIDTH.
  localparam int unsigned SYM_LEVEL_WIDTH = 12;

  // Standard JPEG zigzag scan: zz[k] = coeff[ZZ_ROW[k]][ZZ_COL[k]].
  localparam logic [2:0] ZZ_ROW [NUM_COEFFS] = '{
    3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
    3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
    3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
    3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5,
    3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
  };

  localparam logic [2:0] ZZ_COL [NUM_COEFFS] = '{
    3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2,
    3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2,
    3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
    3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
    3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
  };

  typedef enum logic [2:0] {
    StIdle,
    StDc,
    StScan,
    StZrl,
    StEob
  } state_e;

  typedef struct packed {
    logic [3:0]                         run;
    logic signed [SYM_LEVEL_WIDTH-1:0]  level;
    logic                               sat;
    logic                               eob;
  } sym_t;

  function automatic sym_t make_sym(logic [3:0] run, logic signed [SYM_LEVEL_WIDTH-1:0] level,
                                    logic sat, logic eob);
    sym_t s;
    s.run   = run;
    s.level = level;
    s.sat   = sat;
    s.eob   = eob;
    return s;
  endfunction

endpackage

// File: rtl/zigzag_rle_coeff_sat.sv
// Combinational saturator: clips a wide signed coefficient to the symbol level width.
module zigzag_rle_coeff_sat #(
  parameter int unsigned COEFF_WIDTH = 52,
  parameter int unsigned LEVEL_WIDTH = 12
) (
  input  logic signed [COEFF_WIDTH-1:0] coeff,
  output logic signed [LEVEL_WIDTH-1:0] level,
  output logic                          clip
);

  // The value fits when every bit above the target sign bit repeats that sign bit.
  logic [COEFF_WIDTH-LEVEL_WIDTH:0] upper;
  logic                             fits;

  // Range check and clamp to the most positive / most negative level.
  always_comb begin
    upper = coeff[COEFF_WIDTH-1:LEVEL_WIDTH-1];
    fits  = (upper == '0) || (upper == '1);
    clip  = !fits;
    if (fits) begin
      level = coeff[LEVEL_WIDTH-1:0];
    end else if (coeff[COEFF_WIDTH-1]) begin
      level = {1'b1, {(LEVEL_WIDTH-1){1'b0}}};
    end else begin
      level = {1'b0, {(LEVEL_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/zigzag_rle.sv
// Captures an 8x8 quantized block, scans it in zigzag order and emits (run, level)
// symbols with ZRL and EOB markers on a valid/ready stream.
module zigzag_rle
  import zigzag_rle_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE  = 8,
  parameter int unsigned COEFF_WIDTH = 52,
  parameter int unsigned LEVEL_WIDTH = SYM_LEVEL_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          block_valid,
  input  logic signed [COEFF_WIDTH-1:0] quantized_coeffs [BLOCK_SIZE][BLOCK_SIZE],
  output logic                          in_ready,
  output logic                          block_dropped,
  output logic                          sym_valid,
  input  logic                          sym_ready,
  output logic [3:0]                    sym_run,
  output logic signed [LEVEL_WIDTH-1:0] sym_level,
  output logic                          sym_sat,
  output logic                          sym_eob
);

  // Saturated coefficients, already in zigzag order, ready to be captured.
  logic signed [LEVEL_WIDTH-1:0] cap_level [NUM_COEFFS];
  logic [NUM_COEFFS-1:0]         cap_sat;

  logic signed [LEVEL_WIDTH-1:0] level_q [NUM_COEFFS];
  logic [NUM_COEFFS-1:0]         sat_q;

  state_e     state_q;
  logic       in_ready_q;
  logic       block_dropped_q;
  logic       sym_valid_q;
  sym_t       sym_q;
  logic [5:0] idx_q;
  logic [3:0] run_q;
  logic [1:0] zrl_q;

  logic                          capture;
  logic                          advance;
  logic                          accept;
  logic signed [LEVEL_WIDTH-1:0] cur_level;
  logic                          cur_sat;
  logic                          cur_zero;

  for (genvar k = 0; k < NUM_COEFFS; k++) begin : g_sat
    zigzag_rle_coeff_sat #(
      .COEFF_WIDTH (COEFF_WIDTH),
      .LEVEL_WIDTH (LEVEL_WIDTH)
    ) u_coeff_sat (
      .coeff (quantized_coeffs[ZZ_ROW[k]][ZZ_COL[k]]),
      .level (cap_level[k]),
      .clip  (cap_sat[k])
    );
  end

  assign capture   = block_valid && in_ready_q;
  // The scan may only produce a symbol when the output register is free or draining now.
  assign advance   = !sym_valid_q || sym_ready;
  assign accept    = sym_valid_q && sym_ready;
  assign cur_level = level_q[idx_q];
  assign cur_sat   = sat_q[idx_q];
  assign cur_zero  = (cur_level == '0);

  // Coefficient store; contents are don't-care outside a block, so no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      level_q <= cap_level;
      sat_q   <= cap_sat;
    end
  end

  // Scan controller with registered symbol and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      in_ready_q      <= 1'b1;
      block_dropped_q <= 1'b0;
      sym_valid_q     <= 1'b0;
      sym_q           <= '0;
      idx_q           <= '0;
      run_q           <= '0;
      zrl_q           <= '0;
    end else begin
      block_dropped_q <= block_valid && !in_ready_q;
      if (accept) begin
        sym_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            in_ready_q <= 1'b0;
            idx_q      <= '0;
            run_q      <= '0;
            zrl_q      <= '0;
            state_q    <= StDc;
          end
        end
        StDc: begin
          if (advance) begin
            sym_q       <= make_sym(4'd0, SYM_LEVEL_WIDTH'(level_q[0]), sat_q[0], 1'b0);
            sym_valid_q <= 1'b1;
            idx_q       <= 6'd1;
            state_q     <= StScan;
          end
        end
        StScan: begin
          if (advance) begin
            if (cur_zero) begin
              if (run_q == 4'(RUN_MAX)) begin
                run_q <= '0;
                if (zrl_q != 2'(ZRL_MAX)) begin
                  zrl_q <= zrl_q + 2'd1;
                end
              end else begin
                run_q <= run_q + 4'd1;
              end
              if (idx_q == 6'd63) begin
                state_q <= StEob;
              end else begin
                idx_q <= idx_q + 6'd1;
              end
            end else if (zrl_q != 2'd0) begin
              // Flush pending ZRLs first; this coefficient is revisited afterwards.
              state_q <= StZrl;
            end else begin
              sym_q       <= make_sym(run_q, SYM_LEVEL_WIDTH'(cur_level), cur_sat, 1'b0);
              sym_valid_q <= 1'b1;
              run_q       <= '0;
              if (idx_q == 6'd63) begin
                state_q <= StEob;
              end else begin
                idx_q <= idx_q + 6'd1;
              end
            end
          end
        end
        StZrl: begin
          if (advance) begin
            sym_q       <= make_sym(4'(RUN_MAX), '0, 1'b0, 1'b0);
            sym_valid_q <= 1'b1;
            zrl_q       <= zrl_q - 2'd1;
            if (zrl_q == 2'd1) begin
              state_q <= StScan;
            end
          end
        end
        StEob: begin
          if (sym_valid_q && sym_q.eob) begin
            if (sym_ready) begin
              state_q    <= StIdle;
              in_ready_q <= 1'b1;
            end
          end else if (advance) begin
            // Trailing zeros and pending ZRLs are implied by the EOB.
            sym_q       <= make_sym(4'd0, '0, 1'b0, 1'b1);
            sym_valid_q <= 1'b1;
            run_q       <= '0;
            zrl_q       <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign block_dropped = block_dropped_q;
  assign sym_valid     = sym_valid_q;
  assign sym_run       = sym_q.run;
  assign sym_level     = LEVEL_WIDTH'(sym_q.level);
  assign sym_sat       = sym_q.sat;
  assign sym_eob       = sym_q.eob;

endmodule

// File: tb/tb_zigzag_rle.sv
// Self-checking bench for zigzag_rle: directed blocks plus randomized blocks with
// random backpressure, compared against a list-based symbol model.
module tb_zigzag_rle;

  localparam int unsigned CW = 52;
  localparam int unsigned LW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic block_valid = 1'b0;
  logic sym_ready;
  logic signed [CW-1:0] quantized_coeffs [8][8];
  logic in_ready, block_dropped, sym_valid, sym_sat, sym_eob;
  logic [3:0] sym_run;
  logic signed [LW-1:0] sym_level;

  zigzag_rle #(
    .BLOCK_SIZE  (8),
    .COEFF_WIDTH (CW),
    .LEVEL_WIDTH (LW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .block_valid      (block_valid),
    .quantized_coeffs (quantized_coeffs),
    .in_ready         (in_ready),
    .block_dropped    (block_dropped),
    .sym_valid        (sym_valid),
    .sym_ready        (sym_ready),
    .sym_run          (sym_run),
    .sym_level        (sym_level),
    .sym_sat          (sym_sat),
    .sym_eob          (sym_eob)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    run;
    logic [LW-1:0] level;
    logic          sat;
    logic          eob;
  } exp_sym_t;

  exp_sym_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int sym_cnt = 0;
  int ready_pct = 100;
  int zz_r[64];
  int zz_c[64];
  logic signed [CW-1:0] blk [8][8];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Zigzag order from the anti-diagonal walk: odd diagonals go down-left, even go up-right.
  task automatic build_zigzag();
    int k;
    k = 0;
    for (int s = 0; s <= 14; s++) begin
      for (int i = 0; i < 8; i++) begin
        int r;
        r = (s % 2 == 1) ? i : 7 - i;
        if (s - r >= 0 && s - r <= 7) begin
          zz_r[k] = r;
          zz_c[k] = s - r;
          k++;
        end
      end
    end
  endtask

  task automatic sat_model(input longint v, output int lvl, output bit s);
    longint hi, lo;
    hi = (longint'(1) <<< (LW - 1)) - 1;
    lo = -(longint'(1) <<< (LW - 1));
    s = 1'b1;
    if (v > hi) lvl = int'(hi);
    else if (v < lo) lvl = int'(lo);
    else begin
      lvl = int'(v);
      s = 1'b0;
    end
  endtask

  function automatic exp_sym_t mk(input int run, input int lvl, input bit s, input bit eob);
    exp_sym_t e;
    e.run = 4'(run);
    e.level = LW'(lvl);
    e.sat = s;
    e.eob = eob;
    return e;
  endfunction

  // Expected symbol list for blk, built from the JPEG run-length rules.
  task automatic push_model();
    int lvl, run;
    bit s;
    sat_model(longint'(blk[zz_r[0]][zz_c[0]]), lvl, s);
    exp_q.push_back(mk(0, lvl, s, 1'b0));
    run = 0;
    for (int k = 1; k < 64; k++) begin
      sat_model(longint'(blk[zz_r[k]][zz_c[k]]), lvl, s);
      if (lvl == 0) run++;
      else begin
        while (run >= 16) begin
          exp_q.push_back(mk(15, 0, 1'b0, 1'b0));
          run -= 16;
        end
        exp_q.push_back(mk(run, lvl, s, 1'b0));
        run = 0;
      end
    end
    exp_q.push_back(mk(0, 0, 1'b0, 1'b1));
  endtask

  task automatic clear_blk();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = '0;
  endtask

  task automatic random_blk();
    int zp, m, v;
    logic [63:0] big;
    zp = ($urandom_range(2) == 0) ? 50 : (($urandom_range(1) == 0) ? 85 : 97);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(99) < zp) blk[r][c] = '0;
        else begin
          m = $urandom_range(9);
          if (m < 9) begin
            v = (m < 6) ? int'($urandom_range(40, 1)) : int'($urandom_range(5000, 1));
            if ($urandom_range(1) == 1) v = -v;
            blk[r][c] = CW'(v);
          end else begin
            big = {$urandom, $urandom};
            blk[r][c] = big[CW-1:0];
          end
        end
      end
    end
  endtask

  // Called on a negedge; returns on the negedge after the capture edge.
  task automatic send_block();
    int t;
    t = 0;
    while (!in_ready && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check_eq("in_ready_before_send", in_ready, 1);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) quantized_coeffs[r][c] = blk[r][c];
    block_valid = 1'b1;
    push_model();
    @(negedge clk);
    block_valid = 1'b0;
    check_eq("capture_in_ready_low", in_ready, 0);
    check_eq("capture_no_drop", block_dropped, 0);
  endtask

  task automatic wait_idle(input bit inject);
    bit inj;
    for (int t = 0; t < 4000 && !in_ready; t++) begin
      inj = inject && ($urandom_range(15) == 0);
      if (inj) begin
        block_valid = 1'b1;
        quantized_coeffs[$urandom_range(7)][$urandom_range(7)] = CW'($urandom);
      end
      @(negedge clk);
      if (inj) begin
        block_valid = 1'b0;
        check_eq("drop_pulse", block_dropped, 1);
      end
    end
    check_eq("block_done", in_ready, 1);
    check_eq("queue_drained", exp_q.size(), 0);
  endtask

  // Stream monitor: drives sym_ready, checks stall stability and each accepted symbol.
  always @(negedge clk) begin : mon
    exp_sym_t got, held, e;
    bit stalled;
    if (rst) begin
      stalled = 1'b0;
      sym_ready = 1'b0;
    end else begin
      got.run = sym_run;
      got.level = sym_level;
      got.sat = sym_sat;
      got.eob = sym_eob;
      if (stalled) check_eq("stall_hold", {sym_valid, got}, {1'b1, held});
      sym_ready = ($urandom_range(99) < ready_pct);
      if (sym_valid && sym_ready) begin
        sym_cnt++;
        if (exp_q.size() == 0) check_eq("unexpected_sym", sym_valid, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("sym", got, e);
        end
      end
      stalled = sym_valid && !sym_ready;
      held = got;
    end
  end

  task automatic run_directed(input string tag, input int n_sym);
    int c0;
    c0 = sym_cnt;
    send_block();
    wait_idle(1'b0);
    check_eq(tag, sym_cnt - c0, n_sym);
  endtask

  initial begin : main
    int c0;
    bit found;
    build_zigzag();
    clear_blk();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) quantized_coeffs[r][c] = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_sym_valid", sym_valid, 0);
    check_eq("rst_drop", block_dropped, 0);
    check_eq("rst_run_level", {sym_run, sym_level, sym_sat, sym_eob}, 0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero block: timing and drop on the EOB acceptance edge.
    ready_pct = 100;
    clear_blk();
    c0 = sym_cnt;
    send_block();
    @(negedge clk);
    check_eq("dc_valid", sym_valid, 1);
    repeat (64) @(negedge clk);
    check_eq("in_ready_low_65", in_ready, 0);
    block_valid = 1'b1;
    quantized_coeffs[0][0] = CW'(77);
    @(negedge clk);
    block_valid = 1'b0;
    check_eq("in_ready_high_66", in_ready, 1);
    check_eq("drop_on_eob_accept", block_dropped, 1);
    check_eq("zero_block_syms", sym_cnt - c0, 2);
    repeat (3) @(negedge clk);
    check_eq("no_capture_after_drop", sym_valid, 0);
    check_eq("drop_clears", block_dropped, 0);
    check_eq("zero_block_queue", exp_q.size(), 0);

    // DC, [0][1], [7][7]: zigzag ends and three ZRLs.
    clear_blk();
    blk[0][0] = CW'(5);
    blk[0][1] = -CW'(3);
    blk[7][7] = CW'(1);
    run_directed("zrl3_syms", 7);

    // 20 zeros then zz[21]: one ZRL, trailing zeros dropped.
    clear_blk();
    blk[0][0] = CW'(9);
    blk[zz_r[21]][zz_c[21]] = -CW'(3);
    run_directed("zz21_syms", 4);

    // Saturation in both directions.
    clear_blk();
    blk[0][0] = CW'(5000);
    blk[0][1] = -CW'(70000);
    run_directed("sat_syms", 3);

    // Exactly 16 zeros before a nonzero.
    clear_blk();
    blk[0][0] = CW'(1);
    blk[zz_r[17]][zz_c[17]] = CW'(2);
    run_directed("run16_syms", 4);

    // Random blocks with 50% backpressure and drop attempts while busy.
    ready_pct = 50;
    for (int b = 0; b < 100; b++) begin
      random_blk();
      send_block();
      wait_idle(1'b1);
    end

    // Reset while ZRLs are being emitted, then a clean block.
    ready_pct = 100;
    clear_blk();
    blk[0][0] = CW'(5);
    blk[0][1] = -CW'(3);
    blk[7][7] = CW'(1);
    send_block();
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      found = sym_valid && (sym_run == 4'd15) && !sym_eob;
    end
    check_eq("zrl_seen", found, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_sym_valid", sym_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_payload", {sym_run, sym_level, sym_sat, sym_eob}, 0);
    check_eq("midrst_drop", block_dropped, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_idle", sym_valid, 0);
    run_directed("post_rst_syms", 7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
